// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and reset constants for the instruction-fetch
// sequencer.
//   state_e     - FSM state encoding (IDLE, WAIT, HOLD, DROP)
//   fetch_dbg_t - debug snapshot of the FSM, exported on the fetch_unit
//                 dbg port so checkers can bind to it without reaching
//                 into the hierarchy.
// The machine word width is a module parameter (WORD_SIZE, 32 by default),
// matching the system-wide word size.
package fetch_pkg;

  // IDLE : issue a request for pc_in (unless redirected this cycle)
  // WAIT : one request outstanding, response not yet seen
  // HOLD : instruction captured, offered to decode
  // DROP : request outstanding but a redirect happened; discard the reply
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } state_e;

  typedef struct packed {
    state_e state;        // current FSM state
    logic   outstanding;  // a memory request is in flight (WAIT or DROP)
    logic   holding;      // an instruction is being offered (HOLD)
  } fetch_dbg_t;

  localparam state_e RST_STATE   = IDLE;
  localparam logic   RST_ERR     = 1'b0;
  localparam logic   RST_PC_HALT = 1'b1;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the two handshakes owned by the fetch sequencer.
//
// Instruction memory side (request / acknowledge):
//   imem_req   - one-cycle strobe; imem_addr is valid only while it is high.
//   imem_ack   - response strobe, at least one cycle after imem_req;
//                imem_rdata is valid only while it is high. Exactly one
//                request is outstanding at a time, so acks are never tagged.
//
// Decode side (valid / ready):
//   A transfer happens on a rising clock edge where id_valid && id_ready.
//   Once id_valid rises it stays high, with id_instr/id_pc stable, until
//   the transfer happens or the fetch is flushed by a redirect. id_valid
//   never depends combinationally on id_ready.
//
// Modports:
//   master - the fetch unit (drives requests and the decode payload)
//   slave  - the environment (memory responder and decode stage)
interface fetch_unit_if #(
  parameter int WORD_SIZE = 32
);

  logic                 imem_req;
  logic [WORD_SIZE-1:0] imem_addr;
  logic                 imem_ack;
  logic [WORD_SIZE-1:0] imem_rdata;

  logic                 id_valid;
  logic                 id_ready;
  logic [WORD_SIZE-1:0] id_instr;
  logic [WORD_SIZE-1:0] id_pc;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata,
    output id_valid,
    input  id_ready,
    output id_instr,
    output id_pc
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata,
    input  id_valid,
    output id_ready,
    input  id_instr,
    input  id_pc
  );

endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch sequencer sitting on the output of the
// program-counter register.
//
// Each instruction goes IDLE -> WAIT -> HOLD -> IDLE: the current PC is
// sent to instruction memory, the returned word is held and offered to
// decode, and the PC register is released (pc_halt low) only in the cycle
// decode accepts the word or a redirect loads a new target. A redirect
// while the memory reply is still in flight parks the FSM in DROP until
// the stale reply arrives, so one request is outstanding at most.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous, active-high reset
//   pc_in      - current PC register output
//   pc_halt    - PC register hold (1 = hold)
//   flush      - branch redirect this cycle
//   bus        - fetch_unit_if.master: imem req/ack and decode valid/ready
//   fetch_cnt  - number of instructions accepted by decode (wraps)
//   err        - sticky flag: an ack arrived with no request outstanding
//   dbg        - FSM debug snapshot
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] pc_in,
  output logic                 pc_halt,
  input  logic                 flush,
  fetch_unit_if.master         bus,
  output logic [CNT_WIDTH-1:0] fetch_cnt,
  output logic                 err,
  output fetch_dbg_t           dbg
);

  state_e               state_q,  state_d;
  logic [WORD_SIZE-1:0] req_pc_q, req_pc_d;
  logic [WORD_SIZE-1:0] instr_q,  instr_d;
  logic [WORD_SIZE-1:0] id_pc_q,  id_pc_d;
  logic [CNT_WIDTH-1:0] cnt_q,    cnt_d;
  logic                 err_q,    err_d;

  logic                 issue;     // IDLE and not redirected
  logic                 req_out;   // issue, forced low while in reset
  logic                 accept;    // decode takes the held instruction

  // ---------------------------------------------------------------------
  // Next-state and datapath
  // ---------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    req_pc_d = req_pc_q;
    instr_d  = instr_q;
    id_pc_d  = id_pc_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    issue    = 1'b0;
    accept   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A redirect this cycle means pc_in is about to change, so the
        // request is deferred to the next cycle with the new target.
        if (!flush) begin
          issue    = 1'b1;
          req_pc_d = pc_in;
          state_d  = WAIT;
        end
      end

      WAIT: begin
        if (bus.imem_ack) begin
          if (!flush) begin
            instr_d = bus.imem_rdata;
            id_pc_d = req_pc_q;
            state_d = HOLD;
          end else begin
            // Reply and redirect together: the reply is stale but it also
            // closes the outstanding request, so refetch immediately.
            state_d = IDLE;
          end
        end else if (flush) begin
          state_d = DROP;
        end
      end

      HOLD: begin
        if (flush) begin
          state_d = IDLE;
        end else if (bus.id_ready) begin
          accept  = 1'b1;
          state_d = IDLE;
        end
      end

      DROP: begin
        // Further redirects only move the PC; the reply still has to be
        // swallowed before a new request may go out.
        if (bus.imem_ack) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    // No request is outstanding in IDLE or HOLD, so an ack there is bogus.
    if (bus.imem_ack && ((state_q == IDLE) || (state_q == HOLD))) begin
      err_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // State and data registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RST_STATE;
      req_pc_q <= '0;
      instr_q  <= '0;
      id_pc_q  <= '0;
      cnt_q    <= '0;
      err_q    <= RST_ERR;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
      instr_q  <= instr_d;
      id_pc_q  <= id_pc_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  // The request is combinational from pc_in so a fetch costs no extra
  // cycle; rst gates it because IDLE is also the reset state.
  assign req_out       = issue & ~rst;
  assign bus.imem_req  = req_out;
  assign bus.imem_addr = req_out ? pc_in : '0;

  assign bus.id_valid  = (state_q == HOLD);
  assign bus.id_instr  = instr_q;
  assign bus.id_pc     = id_pc_q;

  // PC moves only when decode takes the instruction or on a redirect.
  assign pc_halt = rst ? RST_PC_HALT
                       : ~(((state_q == HOLD) & bus.id_ready) | flush);

  assign fetch_cnt = cnt_q;
  assign err       = err_q;

  assign dbg.state       = state_q;
  assign dbg.outstanding = (state_q == WAIT) || (state_q == DROP);
  assign dbg.holding     = (state_q == HOLD);

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int W  = 32;
  localparam int CW = 32;

  logic          clk;
  logic          rst;
  logic [W-1:0]  pc_in;
  logic          pc_halt;
  logic          flush;
  logic [CW-1:0] fetch_cnt;
  logic          err;
  fetch_dbg_t    dbg;

  fetch_unit_if #(.WORD_SIZE(W)) bus ();

  fetch_unit #(.WORD_SIZE(W), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .pc_in     (pc_in),
    .pc_halt   (pc_halt),
    .flush     (flush),
    .bus       (bus.master),
    .fetch_cnt (fetch_cnt),
    .err       (err),
    .dbg       (dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bench state ----------------
  int checks = 0;
  int errors = 0;

  // scoreboard: {pc, instr} expected to be offered to decode
  logic [2*W-1:0] exp_q[$];

  // stimulus knobs
  logic [W-1:0]  pc_v;
  logic [W-1:0]  rdata_v;
  logic          flush_v;
  logic          ready_v;
  logic          force_ack;
  int            mem_lat;

  // memory responder / reference state
  logic          mem_pend;
  logic          req_flushed;
  int            mem_wait;
  logic [W-1:0]  mem_data;
  logic [W-1:0]  req_addr;
  logic [CW-1:0] cnt_m;
  logic          err_m;

  typedef struct {
    logic [W-1:0] pc;
    logic [W-1:0] data;
    int           lat;
    int           wait_n;
    int           exp_cycles;
  } vec_t;

  vec_t vecs[6];

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_imem_req"},  bus.imem_req,  1'b0);
    check({tag, "_imem_addr"}, bus.imem_addr, '0);
    check({tag, "_id_valid"},  bus.id_valid,  1'b0);
    check({tag, "_id_instr"},  bus.id_instr,  '0);
    check({tag, "_id_pc"},     bus.id_pc,     '0);
    check({tag, "_fetch_cnt"}, fetch_cnt,     '0);
    check({tag, "_err"},       err,           1'b0);
    check({tag, "_pc_halt"},   pc_halt,       1'b1);
    check({tag, "_state"},     dbg.state,     IDLE);
  endtask

  task automatic model_reset();
    exp_q.delete();
    mem_pend    = 1'b0;
    req_flushed = 1'b0;
    mem_wait    = 0;
    cnt_m       = '0;
    err_m       = 1'b0;
  endtask

  // ---------------- driver: one clock cycle ----------------
  // Inputs are applied on the falling edge, outputs sampled 1 time unit
  // later, and the reference is advanced to reflect the next rising edge.
  task automatic cycle();
    logic           ack_now;
    logic           exp_valid;
    logic           exp_req;
    logic [2*W-1:0] head;
    @(negedge clk);
    pc_in        = pc_v;
    flush        = flush_v;
    bus.id_ready = ready_v;
    ack_now = 1'b0;
    if (mem_pend) begin
      if (mem_wait == 0) ack_now = 1'b1;
      else mem_wait--;
    end
    bus.imem_ack   = ack_now | force_ack;
    bus.imem_rdata = ack_now ? mem_data : (force_ack ? 32'hBAD0_BAD0 : $urandom());
    #1;
    exp_valid = (exp_q.size() != 0);
    exp_req   = !flush_v && !mem_pend && !exp_valid;
    check("id_valid",    bus.id_valid,    exp_valid);
    check("imem_req",    bus.imem_req,    exp_req);
    if (exp_req) check("imem_addr", bus.imem_addr, pc_v);
    check("pc_halt",     pc_halt,         !((exp_valid && ready_v) || flush_v));
    check("fetch_cnt",   fetch_cnt,       cnt_m);
    check("err",         err,             err_m);
    check("outstanding", dbg.outstanding, mem_pend);
    if (exp_valid) begin
      head = exp_q[0];
      check("id_pc",    bus.id_pc,    head[2*W-1:W]);
      check("id_instr", bus.id_instr, head[W-1:0]);
    end
    // advance reference to the next edge
    if (exp_valid && (flush_v || ready_v)) begin
      void'(exp_q.pop_front());
      if (!flush_v) cnt_m++;
    end
    if (force_ack && !mem_pend) err_m = 1'b1;
    if (ack_now) begin
      mem_pend = 1'b0;
      if (!flush_v && !req_flushed) exp_q.push_back({req_addr, mem_data});
    end else if (mem_pend && flush_v) begin
      req_flushed = 1'b1;
    end
    if (exp_req) begin
      mem_pend    = 1'b1;
      mem_wait    = mem_lat - 1;
      mem_data    = rdata_v;
      req_addr    = pc_v;
      req_flushed = 1'b0;
    end
  endtask

  // Run cycles until decode accepts one instruction, holding id_ready low
  // for wait_n cycles of valid first. Returns the cycles consumed.
  task automatic run_fetch(input int wait_n, output int used);
    logic [CW-1:0] start;
    int            hold_n;
    logic          had;
    start  = cnt_m;
    hold_n = 0;
    used   = 0;
    while (cnt_m == start && used < 64) begin
      had     = (exp_q.size() != 0);
      ready_v = had && (hold_n >= wait_n);
      cycle();
      used++;
      if (had) hold_n++;
    end
    ready_v = 1'b0;
    if (cnt_m == start) begin
      checks++;
      errors++;
      $display("FAIL fetch_timeout: got no accept after %0d cycles expected one", used);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    int           used;
    int           done_n;
    int           lat;
    int           wn;
    logic [CW-1:0] cnt_before;

    rst            = 1'b1;
    pc_in          = 32'h1234;
    flush          = 1'b0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    bus.id_ready   = 1'b0;
    pc_v      = 32'h1234;
    rdata_v   = '0;
    flush_v   = 1'b0;
    ready_v   = 1'b0;
    force_ack = 1'b0;
    mem_lat   = 1;
    req_addr  = '0;
    mem_data  = '0;
    model_reset();

    // reset state, with pc_in nonzero so a leaking imem_addr is visible
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");

    // release mid-high-phase so the first IDLE cycle is a full cycle()
    @(posedge clk);
    #2;
    rst = 1'b0;

    // table-driven single fetches
    vecs[0] = '{32'h0000_0000, 32'h2002_0005, 1, 0, 3};
    vecs[1] = '{32'h0000_0004, 32'h1234_5678, 1, 4, 7};
    vecs[2] = '{32'h0000_0008, 32'hCAFE_0001, 3, 0, 5};
    vecs[3] = '{32'h0000_000C, 32'hFFFF_FFFF, 2, 2, 6};
    vecs[4] = '{32'h0000_0010, 32'h0000_0000, 5, 1, 8};
    vecs[5] = '{32'hFFFF_FFFC, 32'hA5A5_5A5A, 1, 1, 4};
    done_n = 0;
    for (int i = 0; i < 6; i++) begin
      pc_v    = vecs[i].pc;
      rdata_v = vecs[i].data;
      mem_lat = vecs[i].lat;
      run_fetch(vecs[i].wait_n, used);
      done_n++;
      check("vec_cycles", used, vecs[i].exp_cycles);
      @(posedge clk);
      #1;
      check("vec_cnt", fetch_cnt, done_n);
    end

    // random latency / back-pressure
    for (int i = 0; i < 6; i++) begin
      lat     = $urandom_range(1, 4);
      wn      = $urandom_range(0, 3);
      pc_v    = 32'h1000 + 32'(i * 4);
      rdata_v = $urandom();
      mem_lat = lat;
      run_fetch(wn, used);
      done_n++;
      check("rand_cycles", used, lat + 2 + wn);
      @(posedge clk);
      #1;
      check("rand_cnt", fetch_cnt, done_n);
    end

    // flush in WAIT, stale reply three cycles later is dropped
    pc_v = 32'h100; rdata_v = 32'hDEAD_BEEF; mem_lat = 4;
    cycle();
    flush_v = 1'b1;
    cycle();
    flush_v = 1'b0; pc_v = 32'h40; rdata_v = 32'h0040_0013;
    cycle();
    cycle();
    check("drop_state", dbg.state, DROP);
    cycle();
    mem_lat = 1;
    run_fetch(0, used);
    check("redirect_cycles", used, 3);

    // flush coincident with the reply
    pc_v = 32'h200; rdata_v = 32'h0BAD_F00D; mem_lat = 2;
    cycle();
    cycle();
    flush_v = 1'b1;
    cycle();
    check("flush_ack_seen", bus.imem_ack, 1'b1);
    check("flush_ack_halt", pc_halt, 1'b0);
    flush_v = 1'b0; pc_v = 32'h80; rdata_v = 32'h0080_0093; mem_lat = 1;
    run_fetch(0, used);
    check("flush_ack_refetch", used, 3);

    // flush in IDLE (no request) and flush in HOLD with ready (no count)
    flush_v = 1'b1; pc_v = 32'h500;
    cycle();
    flush_v = 1'b0; pc_v = 32'h600; rdata_v = 32'h0600_0001; mem_lat = 1;
    cycle();
    cycle();
    cnt_before = cnt_m;
    ready_v = 1'b1; flush_v = 1'b1;
    cycle();
    ready_v = 1'b0; flush_v = 1'b0;
    @(posedge clk);
    #1;
    check("flush_hold_nocount", fetch_cnt, cnt_before);
    check("flush_hold_valid", bus.id_valid, 1'b0);

    // unsolicited ack while holding
    pc_v = 32'h700; rdata_v = 32'h7777_0001; mem_lat = 1;
    cycle();
    cycle();
    cycle();
    force_ack = 1'b1;
    cycle();
    force_ack = 1'b0;
    cycle();
    check("err_set", err, 1'b1);
    cycle();
    check("err_sticky", err, 1'b1);
    check("err_instr_kept", bus.id_instr, 32'h7777_0001);
    ready_v = 1'b1;
    cycle();
    ready_v = 1'b0;

    // asynchronous reset in the middle of WAIT
    pc_v = 32'h300; rdata_v = 32'h3333_0003; mem_lat = 6;
    cycle();
    cycle();
    check("pre_rst_state", dbg.state, WAIT);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    #1;
    check_reset_outputs("async_rst_hold");
    @(posedge clk);
    #2;
    rst = 1'b0;
    pc_v = 32'h0; rdata_v = 32'h2002_0005; mem_lat = 1;
    run_fetch(0, used);
    check("post_rst_cycles", used, 3);
    @(posedge clk);
    #1;
    check("post_rst_cnt", fetch_cnt, 1);
    check("post_rst_err", err, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
